// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: issues one outstanding request at a time to
// instruction memory and buffers returned words in a small FIFO for IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] PC_o,
  output logic        valid_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_s;
  logic [31:0]       fetch_pc_r;
  logic [31:0]       req_pc_r;
  logic [31:0]       fifo_instr_r [FIFO_DEPTH];
  logic [31:0]       fifo_pc_r    [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              req_s;
  logic              fire_s;
  logic              push_s;
  logic              pop_s;
  logic              valid_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign valid_s = (count_r != '0);
  assign pop_s   = valid_s && !stall_i && !flush_i;

  // Request gating and next-state selection; a flush turns any fetch already in flight into a drop
  always_comb begin
    state_s = state_r;
    req_s   = 1'b0;
    fire_s  = 1'b0;
    push_s  = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        req_s  = !rst_i && (count_r < CNT_W'(FIFO_DEPTH));
        fire_s = req_s && imem_gnt_i;
        if (fire_s) begin
          state_s = flush_i ? ST_DROP : ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_s = ST_ISSUE;
          push_s  = !flush_i;
        end else if (flush_i) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_ISSUE;
      end
    endcase
  end

  // Control state: FSM, fetch/request PCs and FIFO pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_ISSUE;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 32'h0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
    end else begin
      state_r <= state_s;
      if (flush_i) begin
        fetch_pc_r <= {branch_target_i[31:2], 2'b00};
      end else if (fire_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (fire_s) begin
        req_pc_r <= fetch_pc_r;
      end
      if (flush_i) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= ptr_inc(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
        if (push_s && !pop_s) begin
          count_r <= count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
          count_r <= count_r - CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents are meaningless while count is zero so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_instr_r[wr_ptr_r] <= imem_rdata_i;
      fifo_pc_r[wr_ptr_r]    <= req_pc_r;
    end
  end

  assign imem_req_o  = req_s;
  assign imem_addr_o = fetch_pc_r;
  assign valid_o     = valid_s;
  assign instr_o     = valid_s ? fifo_instr_r[rd_ptr_r] : 32'h0;
  assign PC_o        = valid_s ? fifo_pc_r[rd_ptr_r]    : 32'h0;

endmodule
